// File: rtl/i2s_slave_xcvr.sv
// I2S slave transceiver: follows an external SCLK/LRCLK, oversampled in the clk domain,
// shifting DW-bit words MSB-first out on SDOUT and assembling SDIN words per channel.
module i2s_slave_xcvr #(
    parameter int DW          = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i2s_sclk,
    input  logic          i2s_lrclk,
    input  logic          i2s_sdin,
    output logic          i2s_sdout,
    input  logic [DW-1:0] tx_din0,
    input  logic [DW-1:0] tx_din1,
    input  logic [1:0]    tx_din_vld,
    output logic [1:0]    tx_din_ack,
    output logic [DW-1:0] rx_dout,
    output logic [1:0]    rx_dout_vld,
    output logic          frame_err
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_DW  = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] lr_sync_r;
    logic [SYNC_STAGES-1:0] sdin_sync_r;
    logic                   sclk_d_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   lr_r;
    logic                   d_r;
    logic                   armed_r;
    logic                   prev_lr_r;
    logic                   ch_r;
    logic                   slot_seen_r;
    logic                   load_pending_r;
    logic                   rx_fire_r;
    logic [CW-1:0]          rx_cnt_r;
    logic [CW-1:0]          tx_cnt_r;
    logic [DW-1:0]          rx_sh_r;
    logic [DW-1:0]          tx_sh_r;
    logic [DW-1:0]          hold0_r;
    logic [DW-1:0]          hold1_r;
    logic                   rise_s;
    logic                   fall_s;
    logic                   slot_start_s;
    logic [DW-1:0]          hold_sel_s;

    assign rise_s       = sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
    assign fall_s       = ~sclk_sync_r[SYNC_STAGES-1] & sclk_d_r;
    assign slot_start_s = rise_r & armed_r & (lr_r != prev_lr_r);
    assign hold_sel_s   = ch_r ? hold1_r : hold0_r;

    // Input synchronizers plus a registered edge stage so lr/d line up with the edge pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_r <= '0;
            lr_sync_r   <= '0;
            sdin_sync_r <= '0;
            sclk_d_r    <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            lr_r        <= 1'b0;
            d_r         <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], i2s_sclk};
            lr_sync_r   <= {lr_sync_r[SYNC_STAGES-2:0], i2s_lrclk};
            sdin_sync_r <= {sdin_sync_r[SYNC_STAGES-2:0], i2s_sdin};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
            rise_r      <= rise_s;
            fall_r      <= fall_s;
            lr_r        <= lr_sync_r[SYNC_STAGES-1];
            d_r         <= sdin_sync_r[SYNC_STAGES-1];
        end
    end

    // Receive path: arming, slot tracking, deserialisation and short-slot detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed_r     <= 1'b0;
            prev_lr_r   <= 1'b0;
            ch_r        <= 1'b0;
            slot_seen_r <= 1'b0;
            rx_cnt_r    <= '0;
            rx_sh_r     <= '0;
            rx_fire_r   <= 1'b0;
            rx_dout     <= '0;
            rx_dout_vld <= 2'b00;
            frame_err   <= 1'b0;
        end else begin
            rx_fire_r   <= 1'b0;
            rx_dout_vld <= 2'b00;
            frame_err   <= 1'b0;
            if (rx_fire_r) begin
                rx_dout           <= rx_sh_r;
                rx_dout_vld[ch_r] <= 1'b1;
            end
            if (rise_r) begin
                if (!armed_r) begin
                    armed_r   <= 1'b1;
                    prev_lr_r <= lr_r;
                end else if (lr_r != prev_lr_r) begin
                    // The bit sampled here is the tail of the previous slot and is dropped
                    prev_lr_r   <= lr_r;
                    ch_r        <= lr_r;
                    rx_cnt_r    <= '0;
                    slot_seen_r <= 1'b1;
                    frame_err   <= slot_seen_r && (rx_cnt_r < CNT_DW);
                end else if (slot_seen_r && (rx_cnt_r < CNT_DW)) begin
                    rx_sh_r   <= {rx_sh_r[DW-2:0], d_r};
                    rx_cnt_r  <= rx_cnt_r + CNT_ONE;
                    rx_fire_r <= (rx_cnt_r == (CNT_DW - CNT_ONE));
                end
            end
        end
    end

    // Transmit path: hold-register load on the first falling edge of a slot, then MSB-first shift
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_pending_r <= 1'b0;
            tx_cnt_r       <= '0;
            tx_sh_r        <= '0;
            hold0_r        <= '0;
            hold1_r        <= '0;
            i2s_sdout      <= 1'b0;
            tx_din_ack     <= 2'b00;
        end else begin
            tx_din_ack <= 2'b00;
            if (slot_start_s) begin
                load_pending_r <= 1'b1;
            end else if (fall_r) begin
                if (load_pending_r) begin
                    load_pending_r <= 1'b0;
                    tx_sh_r        <= hold_sel_s;
                    i2s_sdout      <= hold_sel_s[DW-1];
                    tx_cnt_r       <= CNT_ONE;
                    // Without a valid word the hold register keeps the last sample (underrun repeat)
                    if (tx_din_vld[ch_r]) begin
                        tx_din_ack[ch_r] <= 1'b1;
                        if (ch_r) begin
                            hold1_r <= tx_din1;
                        end else begin
                            hold0_r <= tx_din0;
                        end
                    end
                end else if (slot_seen_r && (tx_cnt_r < CNT_DW)) begin
                    tx_sh_r   <= tx_sh_r << 1;
                    i2s_sdout <= tx_sh_r[DW-2];
                    tx_cnt_r  <= tx_cnt_r + CNT_ONE;
                end else begin
                    i2s_sdout <= 1'b0;
                end
            end
        end
    end

endmodule
